// File: rtl/dpbram_mrport_clr.sv
// Simple-dual-port block-RAM store: one byte-lane write port, NRD replicated read banks,
// write-first bypass and a hardware clear sweep after reset or on request.
module dpbram_mrport_clr #(
  parameter int unsigned   DW       = 36,
  parameter int unsigned   AW       = 9,
  parameter int unsigned   NRD      = 2,
  parameter int unsigned   OUT_REG  = 0,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              init_req,
  output logic              init_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW/9-1:0]   wr_be,
  input  logic [DW-1:0]     wr_data,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_valid
);

  localparam int unsigned NL    = DW / 9;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t        state;
  logic [AW-1:0] clr_ptr;
  logic          idle_c;

  assign idle_c = (state == ST_IDLE);

  // Clear-sweep sequencer; init_busy mirrors the CLEAR state as a register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_CLEAR;
      clr_ptr   <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST) begin
            state     <= ST_IDLE;
            init_busy <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (init_req) begin
            state     <= ST_CLEAR;
            clr_ptr   <= '0;
            init_busy <= 1'b1;
          end
        end
        default: begin
          state     <= ST_CLEAR;
          clr_ptr   <= '0;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  // Shared write port: the sweep owns it while clearing, user writes are dropped then
  logic [NL-1:0] mem_we_c;
  logic [AW-1:0] mem_waddr_c;
  logic [DW-1:0] mem_wdata_c;

  always_comb begin
    mem_we_c    = '0;
    mem_waddr_c = clr_ptr;
    mem_wdata_c = INIT_VAL;
    if (!idle_c) begin
      mem_we_c = '1;
    end else if (wr_en) begin
      mem_we_c    = wr_be;
      mem_waddr_c = wr_addr;
      mem_wdata_c = wr_data;
    end
  end

  for (genvar b = 0; b < NRD; b++) begin : g_bank
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ra;
    logic [DW-1:0] fwd_c;
    logic [DW-1:0] q;
    logic          v;

    assign ra = rd_addr[b*AW +: AW];

    always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < NL; k++) begin
        if (mem_we_c[k]) mem[mem_waddr_c][k*9 +: 9] <= mem_wdata_c[k*9 +: 9];
      end
    end

    // Write-first: lanes written this cycle to the same address bypass the array
    always_comb begin
      fwd_c = mem[ra];
      if (idle_c && wr_en && (wr_addr == ra)) begin
        for (int unsigned k = 0; k < NL; k++) begin
          if (wr_be[k]) fwd_c[k*9 +: 9] = wr_data[k*9 +: 9];
        end
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        q <= '0;
        v <= 1'b0;
      end else begin
        v <= idle_c & rd_en[b];
        if (idle_c && rd_en[b]) q <= fwd_c;
      end
    end

    if (OUT_REG != 0) begin : g_oreg
      logic [DW-1:0] q2;
      logic          v2;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          q2 <= '0;
          v2 <= 1'b0;
        end else begin
          v2 <= v;
          if (v) q2 <= q;
        end
      end

      assign rd_data[b*DW +: DW] = q2;
      assign rd_valid[b]         = v2;
    end else begin : g_direct
      assign rd_data[b*DW +: DW] = q;
      assign rd_valid[b]         = v;
    end
  end

endmodule

// File: tb/tb_dpbram_mrport_clr.sv
// Randomized scoreboard bench: drives a LAT=1 and a LAT=2 instance with identical stimulus
// and checks both against an array-level model of the store and its clear sweep.
module tb_dpbram_mrport_clr;

  localparam int unsigned DW    = 36;
  localparam int unsigned AW    = 9;
  localparam int unsigned NRD   = 2;
  localparam int unsigned NL    = DW / 9;
  localparam int unsigned DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              init_req = 1'b0;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [NL-1:0]     wr_be = '0;
  logic [DW-1:0]     wr_data = '0;
  logic [NRD-1:0]    rd_en = '0;
  logic [NRD*AW-1:0] rd_addr = '0;

  logic              busy [2];
  logic [NRD*DW-1:0] rdd  [2];
  logic [NRD-1:0]    rdv  [2];

  always #5 clk = ~clk;

  dpbram_mrport_clr #(.DW(DW), .AW(AW), .NRD(NRD), .OUT_REG(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .init_req(init_req), .init_busy(busy[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[0]), .rd_valid(rdv[0])
  );

  dpbram_mrport_clr #(.DW(DW), .AW(AW), .NRD(NRD), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .init_req(init_req), .init_busy(busy[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[1]), .rd_valid(rdv[1])
  );

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sbq [2][NRD][$];
  logic [DW-1:0] last_exp [2][NRD];
  logic [DW-1:0] mem_m [DEPTH];
  int unsigned   clr_left = DEPTH;
  int unsigned   cyc = 0;
  int            checks = 0;
  int            errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [NL-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int k = 0; k < int'(NL); k++) if (be[k]) r[k*9 +: 9] = nw[k*9 +: 9];
    return r;
  endfunction

  function automatic logic [DW-1:0] rdat();
    return DW'({$urandom, $urandom});
  endfunction

  function automatic logic [AW-1:0] raddr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
  endfunction

  task automatic model_reset();
    clr_left = DEPTH;
    for (int a = 0; a < int'(DEPTH); a++) mem_m[a] = '0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < int'(NRD); i++) begin
        sbq[d][i].delete();
        last_exp[d][i] = '0;
      end
    end
  endtask

  // One clock of the reference model, evaluated on the inputs about to be sampled
  task automatic model_step();
    logic [AW-1:0] a;
    exp_t          ex;
    if (clr_left != 0) begin
      clr_left--;
      return;
    end
    for (int i = 0; i < int'(NRD); i++) begin
      if (rd_en[i]) begin
        a       = rd_addr[i*AW +: AW];
        ex.data = mem_m[a];
        if (wr_en && wr_addr == a) ex.data = merge(ex.data, wr_data, wr_be);
        for (int unsigned d = 0; d < 2; d++) begin
          ex.due = cyc + 1 + d;
          sbq[d][i].push_back(ex);
        end
      end
    end
    if (wr_en) mem_m[wr_addr] = merge(mem_m[wr_addr], wr_data, wr_be);
    if (init_req) begin
      clr_left = DEPTH;
      for (int k = 0; k < int'(DEPTH); k++) mem_m[k] = '0;
    end
  endtask

  task automatic tick(input logic we, input logic [AW-1:0] wa, input logic [NL-1:0] be,
                      input logic [DW-1:0] wd, input logic [NRD-1:0] re,
                      input logic [NRD*AW-1:0] ra, input logic ir);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    rd_en = re; rd_addr = ra; init_req = ir;
    @(negedge clk); #1;
    if (rstn) model_step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, '0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic rd2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    tick(1'b0, '0, '0, '0, 2'b11, {a1, a0}, 1'b0);
  endtask

  task automatic rnd_tick(input logic ir);
    tick(1'($urandom_range(0, 1)), raddr(), NL'($urandom), rdat(), NRD'($urandom),
         {raddr(), raddr()}, ir);
  endtask

  task automatic wait_sweep_junk();
    while (clr_left != 0) rnd_tick(1'b0);
  endtask

  task automatic do_reset(input logic ir);
    rstn = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy[d] !== 1'b1 || rdv[d] !== '0 || rdd[d] !== '0) begin
        errors++;
        $display("FAIL reset_async dut%0d: busy=%b valid=%b data=%h, want busy=1 valid=0 data=0",
                 d, busy[d], rdv[d], rdd[d]);
      end
    end
    wr_en = 1'b0; rd_en = '0; init_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b1;
    tick(1'b0, '0, '0, '0, '0, '0, ir);
  endtask

  // Monitor: pops the scoreboard on every rd_valid and checks hold / busy every cycle
  always @(negedge clk) begin : mon
    exp_t          ex;
    logic [DW-1:0] act;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < int'(NRD); i++) begin
        act = rdd[d][i*DW +: DW];
        if (rdv[d][i] === 1'b1) begin
          checks++;
          if (sbq[d][i].size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid dut%0d port%0d: data %h at cycle %0d, want no valid",
                     d, i, act, cyc);
          end else begin
            ex = sbq[d][i].pop_front();
            if (ex.due != cyc || act !== ex.data) begin
              errors++;
              $display("FAIL rd_data dut%0d port%0d: got %h at cycle %0d, want %h at cycle %0d",
                       d, i, act, cyc, ex.data, ex.due);
            end
            last_exp[d][i] = ex.data;
          end
        end else begin
          if (sbq[d][i].size() != 0 && sbq[d][i][0].due <= cyc) begin
            checks++;
            errors++;
            ex = sbq[d][i].pop_front();
            $display("FAIL missing_valid dut%0d port%0d: valid=%b at cycle %0d, want data %h",
                     d, i, rdv[d][i], cyc, ex.data);
            last_exp[d][i] = ex.data;
          end
          checks++;
          if (act !== last_exp[d][i]) begin
            errors++;
            $display("FAIL rd_hold dut%0d port%0d: got %h, want held %h", d, i, act, last_exp[d][i]);
          end
        end
      end
      checks++;
      if (busy[d] !== (clr_left != 0)) begin
        errors++;
        $display("FAIL init_busy dut%0d: got %b at cycle %0d, want %b",
                 d, busy[d], cyc, clr_left != 0);
      end
    end
  end

  initial begin
    logic [DW-1:0] da;
    model_reset();
    @(posedge clk); #1;

    // Reset, sweep with ignored traffic and an init_req on the release cycle, then read all
    do_reset(1'b1);
    wait_sweep_junk();
    for (int a = 0; a < int'(DEPTH); a++) rd2(AW'(a), AW'(int'(DEPTH) - 1 - a));

    // Full write then dual-port read of the same entry
    tick(1'b1, AW'(5), 4'hF, 36'h1_2345_6789, '0, '0, 1'b0);
    rd2(AW'(5), AW'(5));

    // Same-cycle partial write and read collision
    tick(1'b1, AW'(7), 4'hF, 36'h0_0000_0000, '0, '0, 1'b0);
    tick(1'b1, AW'(7), 4'b0101, 36'hF_FFFF_FFFF, 2'b11, {AW'(7), AW'(7)}, 1'b0);
    idle(3);

    // Randomized traffic with occasional clear requests
    repeat (1500) rnd_tick(1'($urandom_range(0, 599) == 0));
    wait_sweep_junk();

    // Clear request after writes; write during the sweep must be dropped
    for (int a = 0; a < 4; a++) tick(1'b1, AW'(a), 4'hF, rdat(), '0, '0, 1'b0);
    tick(1'b0, '0, '0, '0, '0, '0, 1'b1);
    tick(1'b1, AW'(9), 4'hF, rdat(), 2'b11, {AW'(9), AW'(9)}, 1'b0);
    wait_sweep_junk();
    for (int a = 0; a < 16; a++) rd2(AW'(a), AW'(15 - a));

    // Read then overwrite in the next cycle, then hold, then re-read
    da = rdat();
    tick(1'b1, AW'(3), 4'hF, da, '0, '0, 1'b0);
    idle(1);
    tick(1'b0, '0, '0, '0, 2'b01, {AW'(0), AW'(3)}, 1'b0);
    tick(1'b1, AW'(3), 4'hF, ~da, 2'b00, '0, 1'b0);
    idle(4);
    rd2(AW'(3), AW'(3));
    idle(3);

    // Reset mid-sweep at pointer 200, then reset with reads in flight
    tick(1'b0, '0, '0, '0, '0, '0, 1'b1);
    idle(200);
    do_reset(1'b0);
    wait_sweep_junk();
    for (int a = 0; a < 8; a++) rd2(AW'(a), AW'(a + 8));
    tick(1'b1, AW'(10), 4'hF, rdat(), '0, '0, 1'b0);
    tick(1'b0, '0, '0, '0, 2'b11, {AW'(10), AW'(10)}, 1'b0);
    do_reset(1'b0);
    wait_sweep_junk();
    rd2(AW'(10), AW'(11));
    repeat (200) rnd_tick(1'b0);
    idle(4);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < int'(NRD); i++) begin
        checks++;
        if (sbq[d][i].size() != 0) begin
          errors++;
          $display("FAIL drain dut%0d port%0d: %0d reads outstanding, want 0",
                   d, i, sbq[d][i].size());
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
